// File: rtl/can_pkg.sv
`default_nettype none
// ============================================================================
// Module   : can_pkg
// Brief    : Shared CAN constants and helpers (CRC-15 and bit timing).
// Revision : 1.0
// ============================================================================
package can_pkg;

    localparam int CAN_CRC_W = 15;
    localparam logic [CAN_CRC_W-1:0] CAN_CRC15_POLY = 15'h4599;

    // Bit-time length in system clocks; shared with the bit-timing logic.
    function automatic int clks_per_bit(input int clk_freq_mhz, input int bit_rate_kbps);
        return (clk_freq_mhz * 1000) / bit_rate_kbps;
    endfunction

    function automatic logic [CAN_CRC_W-1:0] crc15_step(input logic [CAN_CRC_W-1:0] crc_in,
                                                        input logic bit_in);
        logic nxt;
        nxt = bit_in ^ crc_in[CAN_CRC_W-1];
        return {crc_in[CAN_CRC_W-2:0], 1'b0} ^ (nxt ? CAN_CRC15_POLY : '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/can_bit_sampler.sv
`default_nettype none
// ============================================================================
// Module   : can_bit_sampler
// Brief    : Bit-phase counter with a mid-bit sample strobe.
// Revision : 1.0
// ============================================================================
module can_bit_sampler #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sample
);

    localparam int c_PHASE_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_PHASE_W-1:0] c_LAST = c_PHASE_W'(CLKS_PER_BIT - 1);
    localparam logic [c_PHASE_W-1:0] c_MID  = c_PHASE_W'(CLKS_PER_BIT / 2);

    logic [c_PHASE_W-1:0] r_phase;

    // Held at zero while idle so each window starts on phase 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= '0;
        end else if (!en || r_phase == c_LAST) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + 1'b1;
        end
    end

    assign sample = en && (r_phase == c_MID);

endmodule
`default_nettype wire

// File: rtl/can_crc.sv
`default_nettype none
// ============================================================================
// Module   : can_crc
// Brief    : Bit-serial CAN 2.0 CRC-15 generator for the receive path.
// Revision : 1.0
// ============================================================================
module can_crc
    import can_pkg::*;
#(
    parameter int CLK_FREQ_MHZ  = 1,
    parameter int BIT_RATE_KBPS = 250
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 din,
    output logic [CAN_CRC_W-1:0] crc,
    output logic                 crc_ready
);

    localparam int c_CLKS_PER_BIT = clks_per_bit(CLK_FREQ_MHZ, BIT_RATE_KBPS);

    generate
        if (((CLK_FREQ_MHZ * 1000) % BIT_RATE_KBPS) != 0 || c_CLKS_PER_BIT < 2) begin : g_bad_timing
            $error("can_crc: clock/bit-rate ratio must be an integer >= 2");
        end
    endgenerate

    logic                 w_sample;
    logic                 r_en_d;
    logic [CAN_CRC_W-1:0] r_crc;
    logic                 r_crc_ready;

    can_bit_sampler #(
        .CLKS_PER_BIT (c_CLKS_PER_BIT)
    ) u_sampler (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .sample (w_sample)
    );

    // The rising-edge cycle is phase 0, so the clear never meets a sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_d      <= 1'b0;
            r_crc       <= '0;
            r_crc_ready <= 1'b0;
        end else begin
            r_en_d      <= en;
            r_crc_ready <= !en && r_en_d;
            if (en && !r_en_d) begin
                r_crc <= '0;
            end else if (w_sample) begin
                r_crc <= crc15_step(r_crc, din);
            end
        end
    end

    assign crc       = r_crc;
    assign crc_ready = r_crc_ready;

endmodule
`default_nettype wire

// File: tb/tb_can_crc.sv
`default_nettype none
// ============================================================================
// Module   : tb_can_crc
// Brief    : Self-checking bench for can_crc (directed vectors and sequences).
// Revision : 1.0
// ============================================================================
module tb_can_crc;

    localparam int c_CPB = 4;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        din;
    logic [14:0] crc;
    logic        crc_ready;

    int          n_cmp;
    int          n_fail;
    int          pulses;
    logic [14:0] ready_crc;

    typedef struct {
        string        name;
        int           n;
        logic [127:0] bits;
        logic [14:0]  exp;
    } vec_t;

    vec_t vecs[7];

    can_crc #(
        .CLK_FREQ_MHZ  (1),
        .BIT_RATE_KBPS (250)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .din       (din),
        .crc       (crc),
        .crc_ready (crc_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (crc_ready) begin
            pulses    = pulses + 1;
            ready_crc = crc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Independent reference: plain CRC-15/CAN, MSB-first over the window bits.
    function automatic logic [14:0] crc_model(input int n, input logic [127:0] bits);
        logic [15:0] acc;
        acc = 16'h0;
        for (int i = n - 1; i >= 0; i--) begin
            acc = {acc[14:0], 1'b0};
            if (acc[15] ^ bits[i]) acc[14:0] = acc[14:0] ^ 15'h4599;
            acc[15] = 1'b0;
        end
        return acc[14:0];
    endfunction

    // Called on a falling clock edge; returns on a falling clock edge.
    task automatic send_window(input int n, input logic [127:0] bits);
        for (int i = n - 1; i >= 0; i--) begin
            en  = 1'b1;
            din = bits[i];
            repeat (c_CPB) @(negedge clk);
        end
        en  = 1'b0;
        din = 1'($urandom);
    endtask

    task automatic run_and_check(input string name, input int n, input logic [127:0] bits,
                                 input logic [14:0] exp);
        int p0;
        p0 = pulses;
        send_window(n, bits);
        repeat (4) @(negedge clk);
        check({name, "_ready_pulses"}, 32'(pulses - p0), 32'd1);
        check({name, "_crc"}, {17'd0, ready_crc}, {17'd0, exp});
    endtask

    initial begin
        logic [127:0] frame_a;
        logic [127:0] frame_b;
        logic [14:0]  held;
        int           p0;

        n_cmp     = 0;
        n_fail    = 0;
        pulses    = 0;
        ready_crc = '0;

        vecs[0] = '{"one",          1,  128'b1,   15'h4599};
        vecs[1] = '{"zero",         1,  128'b0,   15'h0000};
        vecs[2] = '{"one_zero",     2,  128'b10,  15'h4EAB};
        vecs[3] = '{"one_one",      2,  128'b11,  15'h0B32};
        vecs[4] = '{"zero_one",     2,  128'b01,  15'h4599};
        vecs[5] = '{"one_zero_one", 3,  128'b101, 15'h1D56};
        vecs[6] = '{"zeros82",      82, 128'b0,   15'h0000};

        // Reset with random activity on the inputs.
        rst_n = 1'b0;
        en    = 1'($urandom);
        din   = 1'($urandom);
        #5;
        en    = 1'($urandom);
        din   = 1'($urandom);
        #4;
        check("reset_crc", {17'd0, crc}, 32'd0);
        check("reset_ready", {31'd0, crc_ready}, 32'd0);
        @(negedge clk);
        en    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_crc", {17'd0, crc}, 32'd0);
        check("post_reset_pulses", 32'(pulses), 32'd0);

        for (int v = 0; v < 7; v++) begin
            run_and_check(vecs[v].name, vecs[v].n, vecs[v].bits, vecs[v].exp);
        end

        // Update happens exactly at the mid-bit sample point.
        run_and_check("prime", 2, 128'b11, 15'h0B32);
        en  = 1'b1;
        din = 1'b1;
        @(negedge clk);
        check("phase0_cleared", {17'd0, crc}, 32'd0);
        @(negedge clk);
        check("phase1_stable", {17'd0, crc}, 32'd0);
        @(negedge clk);
        check("phase2_sampled", {17'd0, crc}, 32'h4599);
        din = 1'b0;
        @(negedge clk);
        check("phase3_stable", {17'd0, crc}, 32'h4599);
        en = 1'b0;
        repeat (4) @(negedge clk);

        // Result holds while idle and din toggles are ignored.
        held = crc;
        for (int i = 0; i < 12; i++) begin
            din = ~din;
            @(negedge clk);
        end
        check("idle_hold", {17'd0, crc}, {17'd0, held});

        // Short window ending before the first sample.
        p0 = pulses;
        en  = 1'b1;
        din = 1'b1;
        repeat (2) @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        check("short_pulses", 32'(pulses - p0), 32'd1);
        check("short_crc", {17'd0, ready_crc}, 32'd0);

        // Idle recessive bits, then two back-to-back frames.
        en  = 1'b0;
        din = 1'b1;
        repeat (10 * c_CPB) @(negedge clk);
        frame_a = {$urandom, $urandom, $urandom, $urandom};
        frame_a[127:82] = '0;
        frame_a[81] = 1'b0;
        frame_b = {$urandom, $urandom, $urandom, $urandom};
        frame_b[127:82] = '0;
        frame_b[81] = 1'b0;
        run_and_check("frame_a", 82, frame_a, crc_model(82, frame_a));
        run_and_check("frame_b", 82, frame_b, crc_model(82, frame_b));

        // Reset in the middle of a window.
        p0 = pulses;
        en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            din = 1'($urandom);
            repeat (c_CPB) @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_crc", {17'd0, crc}, 32'd0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("midreset_no_pulse", 32'(pulses - p0), 32'd0);
        run_and_check("after_reset", 1, 128'b1, 15'h4599);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
